// File: rtl/data_mem_responder.sv
// Byte-serial load/store responder: N+1 cycles after handshake for legal accesses, 1 cycle for illegal ones.
// req_ready is high only when idle; requests offered while busy are dropped, never queued.
module data_mem_responder #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;

  state_t                state, state_nx;
  logic                  wr_q;
  logic [2:0]            f3_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [31:0]           wdata_q;
  logic [1:0]            cnt_q;
  logic [31:0]           asm_q;
  logic                  err_q;

  logic [7:0] mem [0:(1<<ADDR_WIDTH)-1];

  logic                  req_illegal;
  logic [1:0]            last_idx;
  logic                  last_byte;
  logic [ADDR_WIDTH-1:0] xfer_addr;
  logic [7:0]            rd_byte;
  logic [7:0]            wr_byte;
  logic [31:0]           ext_data;
  logic                  unused_addr_hi;

  // Address bits above the array depth alias onto the same storage.
  assign unused_addr_hi = ^req_addr[31:ADDR_WIDTH];

  always_comb begin
    req_illegal = 1'b1;
    case (req_funct3)
      3'b000:  req_illegal = 1'b0;
      3'b001:  req_illegal = req_addr[0];
      3'b010:  req_illegal = |req_addr[1:0];
      3'b100:  req_illegal = req_write;
      3'b101:  req_illegal = req_write | req_addr[0];
      default: req_illegal = 1'b1;
    endcase
  end

  always_comb begin
    last_idx = 2'd0;
    case (f3_q[1:0])
      2'b01:   last_idx = 2'd1;
      2'b10:   last_idx = 2'd3;
      default: last_idx = 2'd0;
    endcase
  end

  assign last_byte = (cnt_q == last_idx);
  assign xfer_addr = base_q + ADDR_WIDTH'(cnt_q);
  assign rd_byte   = mem[xfer_addr];
  assign wr_byte   = wdata_q[{cnt_q, 3'b000} +: 8];

  always_comb begin
    ext_data = asm_q;
    case (f3_q)
      3'b000:  ext_data = {{24{asm_q[7]}}, asm_q[7:0]};
      3'b001:  ext_data = {{16{asm_q[15]}}, asm_q[15:0]};
      3'b100:  ext_data = {24'b0, asm_q[7:0]};
      3'b101:  ext_data = {16'b0, asm_q[15:0]};
      default: ext_data = asm_q;
    endcase
  end

  always_comb begin
    state_nx   = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = 32'b0;
    resp_err   = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nx = req_illegal ? RESP : XFER;
      end
      XFER: begin
        if (last_byte) state_nx = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        if (!wr_q && !err_q) resp_rdata = ext_data;
        state_nx   = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      wr_q    <= 1'b0;
      f3_q    <= 3'b0;
      base_q  <= '0;
      wdata_q <= 32'b0;
      cnt_q   <= 2'b0;
      asm_q   <= 32'b0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (req_valid) begin
            wr_q    <= req_write;
            f3_q    <= req_funct3;
            base_q  <= req_addr[ADDR_WIDTH-1:0];
            wdata_q <= req_wdata;
            cnt_q   <= 2'b0;
            asm_q   <= 32'b0;
            err_q   <= req_illegal;
          end
        end
        XFER: begin
          cnt_q <= cnt_q + 2'd1;
          if (!wr_q) asm_q[{cnt_q, 3'b000} +: 8] <= rd_byte;
        end
        default: ;
      endcase
    end
  end

  // A reset landing mid-store suppresses that cycle's byte write.
  always_ff @(posedge clk) begin
    if (!rst && state == XFER && wr_q) mem[xfer_addr] <= wr_byte;
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized scoreboard bench for data_mem_responder against a byte-array reference model.
module tb_data_mem_responder;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [2:0]  req_funct3 = 3'b0;
  logic [31:0] req_addr = 32'b0;
  logic [31:0] req_wdata = 32'b0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  data_mem_responder #(.ADDR_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;
  exp_t q[$];

  logic [7:0] mdl [256];

  function automatic void check(string name, logic [31:0] act, logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  // Reference model: applies a whole access at once and predicts the response.
  task automatic model_issue(input logic w, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] wd, input int t);
    int n;
    bit ill;
    logic [31:0] v;
    exp_t e;
    n   = (f3 == 3'd2) ? 4 : ((f3 == 3'd1 || f3 == 3'd5) ? 2 : 1);
    ill = w ? (f3 > 3'd2) : (f3 == 3'd3 || f3 >= 3'd6);
    if (n == 2 && a[0]) ill = 1'b1;
    if (n == 4 && a[1:0] != 2'b00) ill = 1'b1;
    v = 32'b0;
    if (!ill) begin
      for (int k = 0; k < n; k++) begin
        int idx;
        idx = (int'(a[7:0]) + k) % 256;
        if (w) mdl[idx] = 8'((wd >> (8 * k)) & 32'hFF);
        else   v = v | (32'(mdl[idx]) << (8 * k));
      end
      if (!w && f3 == 3'd0) v = {{24{v[7]}}, v[7:0]};
      if (!w && f3 == 3'd1) v = {{16{v[15]}}, v[15:0]};
    end
    e.err   = ill;
    e.rdata = (w || ill) ? 32'b0 : v;
    e.cyc   = ill ? t + 1 : t + n + 1;
    q.push_back(e);
  endtask

  task automatic junk_req();
    req_valid  = 1'b1;
    req_write  = 1'($urandom);
    req_funct3 = 3'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
  endtask

  // Junk mode keeps req_valid high with garbage while the responder is busy.
  task automatic issue(input logic w, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input bit junk);
    int waited;
    int t;
    waited = 0;
    forever begin
      @(negedge clk);
      if (req_ready) break;
      if (junk) junk_req();
      else req_valid = 1'b0;
      waited++;
      if (waited > 50) begin
        vectors++;
        miscompares++;
        $display("FAIL ready_timeout: req_ready still %b after %0d cycles, required 1", req_ready, waited);
        return;
      end
    end
    req_valid  = 1'b1;
    req_write  = w;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    t = cyc;
    @(posedge clk);
    model_issue(w, f3, a, wd, t);
    #1;
    if (junk) junk_req();
    else req_valid = 1'b0;
  endtask

  logic prev_resp = 1'b0;
  logic prev_rst  = 1'b1;
  always @(negedge clk) begin
    if (!rst) begin
      if (q.size() > 0) check("busy_ready", 32'(req_ready), 32'd0);
      if (prev_resp && !prev_rst) check("ready_after_resp", 32'(req_ready), 32'd1);
      if (resp_valid) begin
        if (q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_resp: resp_valid 1 with rdata %h err %b, required no response", resp_rdata, resp_err);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("resp_rdata", resp_rdata, e.rdata);
          check("resp_err", 32'(resp_err), 32'(e.err));
          check("resp_cycle", 32'(cyc), 32'(e.cyc));
        end
      end else begin
        check("idle_rdata", resp_rdata, 32'd0);
        check("idle_err", 32'(resp_err), 32'd0);
      end
    end
    prev_resp = resp_valid;
    prev_rst  = rst;
  end

  initial begin
    logic [7:0] keep2, keep3;
    int drain;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_ready", 32'(req_ready), 32'd1);
    check("reset_valid", 32'(resp_valid), 32'd0);
    check("reset_rdata", resp_rdata, 32'd0);
    check("reset_err", 32'(resp_err), 32'd0);

    // Give every byte a known value so loads are fully predictable.
    for (int i = 0; i < 256; i++) issue(1'b1, 3'd0, 32'(i), $urandom, 1'b0);

    issue(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 1'b0);
    issue(1'b0, 3'd2, 32'h10, 32'h0, 1'b0);
    issue(1'b0, 3'd0, 32'h13, 32'h0, 1'b0);
    issue(1'b0, 3'd4, 32'h13, 32'h0, 1'b0);
    issue(1'b0, 3'd1, 32'h12, 32'h0, 1'b0);
    issue(1'b0, 3'd5, 32'h10, 32'h0, 1'b0);
    issue(1'b1, 3'd1, 32'h11, 32'h1234, 1'b0);
    issue(1'b0, 3'd2, 32'h10, 32'h0, 1'b0);
    issue(1'b0, 3'd3, 32'h10, 32'h0, 1'b0);

    // Reset lands while byte 2 of the store is in flight: only bytes 0,1 land.
    keep2 = mdl[8'h22];
    keep3 = mdl[8'h23];
    issue(1'b1, 3'd2, 32'h20, 32'hAABBCCDD, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    q.delete();
    mdl[8'h22] = keep2;
    mdl[8'h23] = keep3;
    @(posedge clk);
    #1 rst = 1'b0;
    issue(1'b0, 3'd2, 32'h20, 32'h0, 1'b0);

    issue(1'b1, 3'd0, 32'h110, 32'h5A, 1'b0);
    issue(1'b0, 3'd4, 32'h010, 32'h0, 1'b0);

    issue(1'b0, 3'd2, 32'h10, 32'h0, 1'b1);
    issue(1'b0, 3'd0, 32'h13, 32'h0, 1'b1);
    issue(1'b0, 3'd2, 32'h10, 32'h0, 1'b0);

    for (int i = 0; i < 300; i++) begin
      logic [31:0] a;
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom,
            $urandom_range(0, 3) == 0);
    end

    drain = 0;
    while (q.size() > 0 && drain < 20) begin
      @(negedge clk);
      req_valid = 1'b0;
      drain++;
    end
    if (q.size() > 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout: %0d responses outstanding, required 0", q.size());
    end
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
